// File: rtl/gcd_pkg.sv
// Shared types and defaults for the subtract-based GCD block.
package gcd_pkg;

    localparam int GCD_WIDTH    = 32;
    localparam int GCD_MAX_ITER = 1048576;
    localparam int GCD_ITER_W   = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } gcd_state_e;

endpackage

// File: rtl/gcd_ctrl.sv
// Control FSM for the subtract-based GCD datapath: request intake, zero bypass,
// iteration steering with a timeout abort, and result return.
module gcd_ctrl
    import gcd_pkg::*;
#(
    parameter int WIDTH    = GCD_WIDTH,
    parameter int MAX_ITER = GCD_MAX_ITER,
    parameter int ITER_W   = GCD_ITER_W
) (
    input  logic              clk,
    input  logic              rst,
    // Both channels: a transfer happens on a rising clk edge where valid and ready are both high.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WIDTH-1:0]  req_a,
    input  logic [WIDTH-1:0]  req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_data,
    output logic              res_err,
    output logic              ld_a,
    output logic              ld_b,
    output logic              sub_a,
    output logic              sub_b,
    input  logic              a_gt_b,
    input  logic              b_gt_a,
    input  logic              a_eq_b,
    input  logic [WIDTH-1:0]  gcd_in,
    output logic              busy,
    output logic [ITER_W-1:0] iter_count,
    output gcd_state_e        state_dbg
);

    localparam logic [ITER_W-1:0] ITER_SAT  = ITER_W'(MAX_ITER);
    // Last RUN cycle allowed to iterate; the counter lands on MAX_ITER-1 on abort.
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 2);

    gcd_state_e state, state_nxt;
    logic       zero_op;
    logic       timeout;

    assign zero_op   = (req_a == '0) || (req_b == '0);
    assign timeout   = (state == RUN) && !a_eq_b && (iter_count >= ITER_LAST);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        res_valid = 1'b0;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        sub_a     = 1'b0;
        sub_b     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = zero_op ? DONE : LOAD;
            end
            LOAD: begin
                ld_a      = 1'b1;
                ld_b      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (a_eq_b)       state_nxt = CAPTURE;
                else if (timeout) state_nxt = DONE;
                else if (a_gt_b)  sub_a = 1'b1;
                else if (b_gt_a)  sub_b = 1'b1;
            end
            CAPTURE: state_nxt = DONE;
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            res_data   <= '0;
            res_err    <= 1'b0;
            iter_count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        iter_count <= '0;
                        if (zero_op) begin
                            res_data <= req_a | req_b;
                            res_err  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (iter_count != ITER_SAT) iter_count <= iter_count + ITER_W'(1);
                    if (timeout) begin
                        res_data <= '0;
                        res_err  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    res_data <= gcd_in;
                    res_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: two instances (default and MAX_ITER=8) each paired with a
// behavioural subtract datapath, checked against a Euclid-based reference.
module tb_gcd_ctrl;
    import gcd_pkg::*;

    localparam int W       = 32;
    localparam int T_MAX   = 8;
    localparam int BUDGET  = 600;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         sel = 1'b0;
    logic         req_valid = 1'b0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         res_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // ---------------- instance with default parameters ----------------
    logic d_req_valid, d_req_ready, d_res_valid, d_res_err, d_ld_a, d_ld_b, d_sub_a, d_sub_b;
    logic d_gt, d_lt, d_eq, d_busy;
    logic [W-1:0] d_res_data, d_a, d_b, d_g;
    logic [31:0]  d_iter;
    gcd_state_e   d_state;

    assign d_req_valid = req_valid & ~sel;

    gcd_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(d_req_valid), .req_ready(d_req_ready), .req_a(req_a), .req_b(req_b),
        .res_valid(d_res_valid), .res_ready(res_ready), .res_data(d_res_data), .res_err(d_res_err),
        .ld_a(d_ld_a), .ld_b(d_ld_b), .sub_a(d_sub_a), .sub_b(d_sub_b),
        .a_gt_b(d_gt), .b_gt_a(d_lt), .a_eq_b(d_eq), .gcd_in(d_g),
        .busy(d_busy), .iter_count(d_iter), .state_dbg(d_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_a <= '0; d_b <= '0; d_g <= '0;
        end else begin
            if (d_ld_a) d_a <= req_a; else if (d_sub_a) d_a <= d_a - d_b;
            if (d_ld_b) d_b <= req_b; else if (d_sub_b) d_b <= d_b - d_a;
            if (d_a == d_b) d_g <= d_a;
        end
    end
    assign d_gt = d_a > d_b;
    assign d_lt = d_b > d_a;
    assign d_eq = d_a == d_b;

    // ---------------- instance with a short timeout ----------------
    logic t_req_valid, t_req_ready, t_res_valid, t_res_err, t_ld_a, t_ld_b, t_sub_a, t_sub_b;
    logic t_gt, t_lt, t_eq, t_busy;
    logic [W-1:0] t_res_data, t_a, t_b, t_g;
    logic [31:0]  t_iter;
    gcd_state_e   t_state;

    assign t_req_valid = req_valid & sel;

    gcd_ctrl #(.WIDTH(W), .MAX_ITER(T_MAX), .ITER_W(32)) dut_t (
        .clk(clk), .rst(rst),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_a(req_a), .req_b(req_b),
        .res_valid(t_res_valid), .res_ready(res_ready), .res_data(t_res_data), .res_err(t_res_err),
        .ld_a(t_ld_a), .ld_b(t_ld_b), .sub_a(t_sub_a), .sub_b(t_sub_b),
        .a_gt_b(t_gt), .b_gt_a(t_lt), .a_eq_b(t_eq), .gcd_in(t_g),
        .busy(t_busy), .iter_count(t_iter), .state_dbg(t_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_a <= '0; t_b <= '0; t_g <= '0;
        end else begin
            if (t_ld_a) t_a <= req_a; else if (t_sub_a) t_a <= t_a - t_b;
            if (t_ld_b) t_b <= req_b; else if (t_sub_b) t_b <= t_b - t_a;
            if (t_a == t_b) t_g <= t_a;
        end
    end
    assign t_gt = t_a > t_b;
    assign t_lt = t_b > t_a;
    assign t_eq = t_a == t_b;

    // Outputs of whichever instance is under test.
    logic         o_req_ready, o_res_valid, o_res_err, o_ld_a, o_ld_b, o_sub_a, o_sub_b, o_busy;
    logic [W-1:0] o_res_data;
    logic [31:0]  o_iter;
    assign o_req_ready = sel ? t_req_ready : d_req_ready;
    assign o_res_valid = sel ? t_res_valid : d_res_valid;
    assign o_res_err   = sel ? t_res_err   : d_res_err;
    assign o_res_data  = sel ? t_res_data  : d_res_data;
    assign o_ld_a      = sel ? t_ld_a      : d_ld_a;
    assign o_ld_b      = sel ? t_ld_b      : d_ld_b;
    assign o_sub_a     = sel ? t_sub_a     : d_sub_a;
    assign o_sub_b     = sel ? t_sub_b     : d_sub_b;
    assign o_busy      = sel ? t_busy      : d_busy;
    assign o_iter      = sel ? t_iter      : d_iter;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: subtraction count = sum of Euclid quotients minus the final equal step.
    task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input int max_iter,
                             output logic [W-1:0] data, output logic err, output int iter,
                             output int lat, output int subs);
        longint unsigned x, y, t;
        longint s;
        if (a == 0 || b == 0) begin
            data = a | b; err = 1'b0; iter = 0; lat = 1; subs = 0;
            return;
        end
        x = a; y = b; s = 0;
        while (y != 0) begin
            s += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        s -= 1;
        if (s <= max_iter - 2) begin
            data = W'(x); err = 1'b0; iter = int'(s) + 1; lat = 4 + int'(s); subs = int'(s);
        end else begin
            data = '0; err = 1'b1; iter = max_iter - 1; lat = max_iter + 1; subs = max_iter - 2;
        end
    endtask

    // Drives one request on the selected instance and checks the whole transaction.
    task automatic run_op(input string name, input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input logic [W-1:0] e_data, input logic e_err,
                          input int e_iter, input int e_lat, input int e_ld, input int e_subs,
                          input int e_sa, input int e_sb);
        int lat, n_ld, n_sa, n_sb, bad;
        logic [W-1:0] got;
        sel = s; req_a = a; req_b = b; req_valid = 1'b1;
        exp_q.push_back(e_data);
        #1;
        check({name, " req_ready"}, 64'(o_req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; n_ld = 0; n_sa = 0; n_sb = 0; bad = 0;
        while (!o_res_valid && lat < BUDGET) begin
            if (o_ld_a) n_ld++;
            if (o_sub_a) n_sa++;
            if (o_sub_b) n_sb++;
            if (o_ld_a !== o_ld_b || (o_sub_a && o_sub_b) || ((o_sub_a || o_sub_b) && o_ld_a)) bad++;
            if (o_req_ready || !o_busy) bad++;
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(e_lat));
        got = exp_q.pop_front();
        check({name, " res_data"}, 64'(o_res_data), 64'(got));
        check({name, " res_err"}, 64'(o_res_err), 64'(e_err));
        check({name, " iter_count"}, 64'(o_iter), 64'(e_iter));
        check({name, " ld_pulses"}, 64'(n_ld), 64'(e_ld));
        check({name, " sub_total"}, 64'(n_sa + n_sb), 64'(e_subs));
        if (e_sa >= 0) begin
            check({name, " sub_a_count"}, 64'(n_sa), 64'(e_sa));
            check({name, " sub_b_count"}, 64'(n_sb), 64'(e_sb));
        end
        check({name, " ctrl_rules"}, 64'(bad), 64'd0);
        check({name, " done_ctrl_idle"},
              64'({o_ld_a, o_ld_b, o_sub_a, o_sub_b, o_req_ready, o_busy}), 64'b000001);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({name, " done_hold"},
                  {o_res_valid, o_res_err, o_req_ready, o_ld_a, o_sub_a, o_sub_b, o_res_data},
                  {1'b1, e_err, 1'b0, 1'b0, 1'b0, 1'b0, e_data});
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({name, " back_to_idle"}, 64'({o_req_ready, o_res_valid, o_busy}), 64'b100);
    endtask

    typedef struct {
        bit           s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           hold;
        logic [W-1:0] data;
        bit           err;
        int           iter;
        int           lat;
        int           ld;
        int           sa;
        int           sb;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [W-1:0] ra, rb, m_data;
        logic         m_err;
        int           m_iter, m_lat, m_subs;

        //          sel  a             b             hold data          err iter lat  ld sa  sb
        vecs[0]  = '{0, 32'd7,        32'd7,        0, 32'd7,        0,  1,   4, 1,  0, 0};
        vecs[1]  = '{0, 32'd12,       32'd18,       1, 32'd6,        0,  3,   6, 1,  1, 1};
        vecs[2]  = '{0, 32'd0,        32'd25,       0, 32'd25,       0,  0,   1, 0,  0, 0};
        vecs[3]  = '{0, 32'd0,        32'd0,        0, 32'd0,        0,  0,   1, 0,  0, 0};
        vecs[4]  = '{0, 32'd21,       32'd14,       5, 32'd7,        0,  3,   6, 1,  1, 1};
        vecs[5]  = '{0, 32'd40,       32'd0,        2, 32'd40,       0,  0,   1, 0,  0, 0};
        vecs[6]  = '{0, 32'd100,      32'd1,        0, 32'd1,        0, 100, 103, 1, 99, 0};
        vecs[7]  = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0,  1,   4, 1,  0, 0};
        vecs[8]  = '{0, 32'h80000000, 32'd0,        0, 32'h80000000, 0,  0,   1, 0,  0, 0};
        vecs[9]  = '{1, 32'd1,        32'd100,      0, 32'd0,        1,  7,   9, 1,  0, 6};
        vecs[10] = '{1, 32'd1,        32'd7,        0, 32'd1,        0,  7,  10, 1,  0, 6};
        vecs[11] = '{1, 32'd1,        32'd8,        3, 32'd0,        1,  7,   9, 1,  0, 6};
        vecs[12] = '{1, 32'd8,        32'd8,        0, 32'd8,        0,  1,   4, 1,  0, 0};
        vecs[13] = '{1, 32'd5,        32'd3,        0, 32'd1,        0,  4,   7, 1,  2, 1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_state_dut", 64'({d_req_ready, d_res_valid, d_busy, d_ld_a, d_ld_b, d_sub_a, d_sub_b}), 64'b1000000);
        check("reset_state_t", 64'({t_req_ready, t_res_valid, t_busy, t_ld_a, t_ld_b, t_sub_a, t_sub_b}), 64'b1000000);
        check("reset_regs", {d_res_data, d_iter}, 64'd0);
        check("reset_err", 64'({d_res_err, t_res_err}), 64'd0);
        check("reset_dbg_state", 64'(d_state), 64'(IDLE));
        rst = 1'b0;
        @(posedge clk); #1;
        check("after_release_idle", 64'({d_req_ready, d_busy, d_res_valid}), 64'b100);

        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].hold,
                   vecs[i].data, vecs[i].err, vecs[i].iter, vecs[i].lat, vecs[i].ld,
                   vecs[i].sa + vecs[i].sb, vecs[i].sa, vecs[i].sb);

        // Reset in the middle of a long run abandons the job.
        sel = 1'b0; req_a = 32'd1000; req_b = 32'd3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrun_busy", 64'(d_busy), 64'd1);
        rst = 1'b1;
        #1;
        check("midrun_reset_outputs", 64'({d_busy, d_req_ready, d_res_valid, d_ld_a, d_sub_a, d_sub_b}), 64'b010000);
        check("midrun_reset_regs", {d_res_data, d_iter}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrun_no_response", 64'({d_res_valid, d_req_ready}), 64'b01);
        run_op("after_reset_9_6", 1'b0, 32'd9, 32'd6, 0, 32'd3, 1'b0, 3, 6, 1, 2, 1, 1);

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 255));
            rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 255));
            ref_model(ra, rb, GCD_MAX_ITER, m_data, m_err, m_iter, m_lat, m_subs);
            run_op($sformatf("rand_dut%0d(%0d,%0d)", i, ra, rb), 1'b0, ra, rb, $urandom_range(0, 3),
                   m_data, m_err, m_iter, m_lat, (ra != 0 && rb != 0) ? 1 : 0, m_subs, -1, -1);
        end
        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom_range(0, 20));
            rb = W'($urandom_range(1, 20));
            ref_model(ra, rb, T_MAX, m_data, m_err, m_iter, m_lat, m_subs);
            run_op($sformatf("rand_t%0d(%0d,%0d)", i, ra, rb), 1'b1, ra, rb, $urandom_range(0, 3),
                   m_data, m_err, m_iter, m_lat, (ra != 0) ? 1 : 0, m_subs, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
